// File: rtl/can_resp_timeout_ctrl.sv
// Per-request response supervisor: transmit, supervise the response window through the
// external timeout timer, retransmit on timeout, and report an error once retries run out.
//
// state     | meaning
// IDLE      | no transaction; req_ready follows !timeoutrst
// SEND      | one-cycle tx_start pulse
// WAIT_TX   | timer running, waiting for the frame to leave
// WAIT_RESP | timer running, waiting for the response
// CLEAR     | timer disabled until its flag drops (at least 2 cycles)
module can_resp_timeout_ctrl #(
  parameter int MAX_RETRY = 3,
  parameter int BUS_ID_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [BUS_ID_W-1:0] req_bus_id,
  output logic                req_ready,
  output logic                tx_start,
  input  logic                tx_done,
  input  logic                rx_resp,
  output logic                entimeout,
  input  logic                timeoutrst,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BUS_ID_W-1:0] err_bus_id,
  output logic [3:0]          retry_cnt
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RESP, CLEAR} state_t;

  localparam logic [3:0] MAX_R     = 4'(MAX_RETRY);
  localparam logic [1:0] GUARD_LD  = 2'd1;

  state_t              state, state_nxt;
  logic [BUS_ID_W-1:0] bus_id, bus_id_nxt, err_bus_id_nxt;
  logic [1:0]          guard, guard_nxt;
  logic [3:0]          retry_cnt_nxt;
  logic                req_ready_nxt, tx_start_nxt, entimeout_nxt, busy_nxt, done_nxt, err_nxt;
  logic                accept, resp_hit, tmo_hit, retry_ok;

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign resp_hit = rx_resp && (state inside {WAIT_TX, WAIT_RESP, CLEAR});
  // a response in the same cycle as the timeout wins
  assign tmo_hit  = timeoutrst && !rx_resp && (state inside {WAIT_TX, WAIT_RESP});
  assign retry_ok = retry_cnt < MAX_R;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bus_id     <= '0;
      guard      <= '0;
      req_ready  <= 1'b0;
      tx_start   <= 1'b0;
      entimeout  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_bus_id <= '0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      bus_id     <= bus_id_nxt;
      guard      <= guard_nxt;
      req_ready  <= req_ready_nxt;
      tx_start   <= tx_start_nxt;
      entimeout  <= entimeout_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      err_bus_id <= err_bus_id_nxt;
      retry_cnt  <= retry_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = SEND;
      SEND:      state_nxt = WAIT_TX;
      WAIT_TX: begin
        if (resp_hit)     state_nxt = IDLE;
        else if (tmo_hit) state_nxt = retry_ok ? CLEAR : IDLE;
        else if (tx_done) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_hit)     state_nxt = IDLE;
        else if (tmo_hit) state_nxt = retry_ok ? CLEAR : IDLE;
      end
      CLEAR: begin
        if (resp_hit)                          state_nxt = IDLE;
        else if (guard == 2'd0 && !timeoutrst) state_nxt = SEND;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    req_ready_nxt  = (state_nxt == IDLE) && !timeoutrst;
    tx_start_nxt   = (state_nxt == SEND);
    entimeout_nxt  = (state_nxt inside {WAIT_TX, WAIT_RESP});
    busy_nxt       = (state_nxt != IDLE);
    done_nxt       = resp_hit;
    err_nxt        = tmo_hit && !retry_ok;
    err_bus_id_nxt = err_nxt ? bus_id : err_bus_id;
    bus_id_nxt     = accept ? req_bus_id : bus_id;

    retry_cnt_nxt = retry_cnt;
    if (accept)
      retry_cnt_nxt = 4'd0;
    else if (tmo_hit && retry_ok)
      retry_cnt_nxt = retry_cnt + 4'd1;

    // guard down-counter: reloaded outside CLEAR, terminal count 0 permits exit
    guard_nxt = guard;
    if (state != CLEAR)
      guard_nxt = GUARD_LD;
    else if (guard != 2'd0)
      guard_nxt = guard - 2'd1;
  end

endmodule

// File: tb/tb_can_resp_timeout_ctrl.sv
// Bench for can_resp_timeout_ctrl: timer model, auto-responder, directed tests,
// and a scoreboard monitor that checks every done/err against queued expectations.
module tb_can_resp_timeout_ctrl;

  typedef struct {
    bit         is_err;
    logic [3:0] retry;
    int         ntx;
    logic [4:0] bus;
    bit         chk_clear;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] req_bus_id = '0;
  logic       tx_done = 1'b0;
  logic       rx_auto = 1'b0;
  logic       rx_man = 1'b0;
  logic       rx_resp;
  logic       req_ready, tx_start, entimeout, busy, done, err;
  logic [4:0] err_bus_id;
  logic [3:0] retry_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  int   time_limit = 100;
  int   resp_attempt = 0;
  int   attempt = 0;

  logic tmr_en_q = 1'b0;
  int   tmr_cnt = 0;
  logic timeoutrst = 1'b0;

  assign rx_resp = rx_auto | rx_man;

  always #5 clk = ~clk;

  can_resp_timeout_ctrl #(.MAX_RETRY(3), .BUS_ID_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_bus_id(req_bus_id), .req_ready(req_ready),
    .tx_start(tx_start), .tx_done(tx_done), .rx_resp(rx_resp),
    .entimeout(entimeout), .timeoutrst(timeoutrst),
    .busy(busy), .done(done), .err(err),
    .err_bus_id(err_bus_id), .retry_cnt(retry_cnt)
  );

  // Timeout timer: flag rises time_limit+1 cycles after enable, drops 2 edges after enable falls
  always @(posedge clk) begin
    tmr_en_q <= entimeout;
    if (!tmr_en_q) begin
      tmr_cnt    <= 0;
      timeoutrst <= 1'b0;
    end else if (tmr_cnt >= time_limit - 1) begin
      timeoutrst <= 1'b1;
    end else begin
      tmr_cnt <= tmr_cnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_txn(input bit is_err, input int retry, input int ntx,
                            input int bus, input bit chk_clear);
    exp_t e;
    e.is_err = is_err; e.retry = 4'(retry); e.ntx = ntx; e.bus = 5'(bus); e.chk_clear = chk_clear;
    sb.push_back(e);
  endtask

  // tx_done 3 cycles after each tx_start; rx_resp 10 cycles after tx_done on the chosen attempt
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && rst) begin
        attempt++;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        if (attempt == resp_attempt) begin
          repeat (9) @(negedge clk);
          rx_auto = 1'b1;
          @(negedge clk);
          rx_auto = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    int   ntx = 0;
    int   clr_run = 0;
    int   clr_min = 1000;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ntx = 0; clr_run = 0; clr_min = 1000;
      end else begin
        if (tx_start) begin
          ntx++;
          if (clr_run > 0 && clr_run < clr_min) clr_min = clr_run;
          clr_run = 0;
        end else if (busy && !entimeout) begin
          clr_run++;
        end
        if (done || err) begin
          check("done_err_exclusive", int'(done && err), 0);
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_end: done=%0d err=%0d with no expectation queued", done, err);
          end else begin
            e = sb.pop_front();
            check("end_kind_err", int'(err), int'(e.is_err));
            check("end_retry_cnt", int'(retry_cnt), int'(e.retry));
            check("end_tx_count", ntx, e.ntx);
            check("end_entimeout", int'(entimeout), 0);
            check("end_busy", int'(busy), 0);
            if (e.is_err) check("end_err_bus_id", int'(err_bus_id), int'(e.bus));
            if (e.chk_clear) check("clear_ge2_cycles", int'(clr_min >= 2), 1);
          end
          ntx = 0; clr_run = 0; clr_min = 1000;
        end
      end
    end
  end

  task automatic do_req(input logic [4:0] id);
    int n = 0;
    attempt    = 0;
    req_bus_id = id;
    req_valid  = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL req_ready_wait: req_ready stayed 0 for %0d cycles", n);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("tx_start_k1", int'(tx_start), 1);
    check("busy_k1", int'(busy), 1);
    check("entimeout_k1", int'(entimeout), 0);
    @(negedge clk);
    check("entimeout_k2", int'(entimeout), 1);
    check("tx_start_k2", int'(tx_start), 0);
  endtask

  task automatic wait_end(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || err) && n < limit);
    if (!(done || err)) begin
      n_chk++; n_fail++;
      $display("FAIL wait_end: no done/err within %0d cycles", limit);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, bad, n, ntx_l;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_entimeout", int'(entimeout), 0);
    check("rst_done_err", int'(done | err), 0);
    check("rst_err_bus_id", int'(err_bus_id), 0);
    check("rst_retry_cnt", int'(retry_cnt), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_req_ready", int'(req_ready), 1);

    // Normal transaction
    time_limit = 100; resp_attempt = 1;
    expect_txn(0, 0, 1, 0, 0);
    do_req(5'd5);
    wait_end(300);
    @(negedge clk);
    check("normal_entimeout_after_done", int'(entimeout), 0);
    check("normal_done_one_cycle", int'(done), 0);
    check("normal_retry_held", int'(retry_cnt), 0);
    repeat (4) @(negedge clk);

    // One retry
    time_limit = 20; resp_attempt = 2;
    expect_txn(0, 1, 2, 0, 1);
    do_req(5'd10);
    wait_end(300);
    @(negedge clk);
    check("retry1_retry_held", int'(retry_cnt), 1);
    repeat (4) @(negedge clk);

    // Retries exhausted
    time_limit = 20; resp_attempt = 0;
    expect_txn(1, 3, 4, 17, 1);
    do_req(5'd17);
    wait_end(600);
    @(negedge clk);
    check("exh_err_one_cycle", int'(err), 0);
    check("exh_err_bus_id_held", int'(err_bus_id), 17);
    check("exh_retry_held", int'(retry_cnt), 3);
    check("exh_busy", int'(busy), 0);

    // rx_resp together with timeoutrst in WAIT_RESP
    time_limit = 20; resp_attempt = 0;
    expect_txn(0, 0, 1, 0, 0);
    do_req(5'd7);
    n = 0;
    while (!timeoutrst && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("simul_timeout_seen", int'(timeoutrst), 1);
    rx_man = 1'b1;
    @(negedge clk);
    rx_man = 1'b0;
    check("simul_done", int'(done), 1);
    ntx_l = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start) ntx_l++;
    end
    check("simul_no_extra_tx", ntx_l, 0);
    check("simul_retry_unchanged", int'(retry_cnt), 0);

    // Back-to-back: request held across an err
    time_limit = 20; resp_attempt = 0;
    expect_txn(1, 3, 4, 9, 1);
    expect_txn(0, 0, 1, 0, 0);
    do_req(5'd9);
    req_bus_id = 5'd3;
    req_valid  = 1'b1;
    n = 0;
    while (!err && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("b2b_err_seen", int'(err), 1);
    check("b2b_req_ready_at_err", int'(req_ready), 0);
    attempt = 0; resp_attempt = 1;
    gap = 0; bad = 0;
    do begin
      @(negedge clk);
      gap++;
      if (req_ready && timeoutrst) bad = 1;
    end while (!tx_start && gap < 50);
    req_valid = 1'b0;
    check("b2b_tx_start_seen", int'(tx_start), 1);
    check("b2b_gap_ge2", int'(gap >= 2), 1);
    check("b2b_ready_gated", bad, 0);
    wait_end(300);
    repeat (4) @(negedge clk);

    // Reset mid-transaction in WAIT_RESP
    time_limit = 100; resp_attempt = 0;
    do_req(5'd12);
    repeat (6) @(negedge clk);
    check("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_entimeout", int'(entimeout), 0);
    check("mid_rst_req_ready", int'(req_ready), 0);
    check("mid_rst_err_bus_id", int'(err_bus_id), 0);
    check("mid_rst_retry_cnt", int'(retry_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_req_ready_back", int'(req_ready), 1);
    check("mid_timeoutrst_low", int'(timeoutrst), 0);
    repeat (5) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
